// File: rtl/rf_wb_arbiter_pkg.sv
// Shared widths and types for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = XLEN;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_ALU  = 2'd1,
    SRC_FIFO = 2'd2
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO with combinational head output; DEPTH must be a power of two.
module wb_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 37
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rptr;
  logic [AW-1:0]    wptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Merges the in-order WB stage and buffered MDU results onto the single RF write port,
// with ALU priority, a starvation guard and a pending-write scoreboard for ID.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mdu_valid,
  output logic              mdu_ready,
  input  logic [REG_AW-1:0] mdu_rd,
  input  logic [DATA_W-1:0] mdu_data,
  input  logic              mdu_issue,
  input  logic [REG_AW-1:0] mdu_issue_rd,
  output logic [XLEN-1:0]   busy,
  output logic              RFWr,
  output logic [REG_AW-1:0] WrDtAdr,
  output logic [DATA_W-1:0] WrDt,
  output logic              stall_req
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [SW-1:0] STARVE_ONE = SW'(1);

  wb_entry_t                 push_entry;
  wb_entry_t                 head;
  logic [$bits(wb_entry_t)-1:0] head_bits;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      fifo_push;
  logic                      fifo_pop;
  wb_src_t                   src;
  logic [REG_AW-1:0]         win_rd;
  logic [DATA_W-1:0]         win_data;
  logic [SW-1:0]             starve;
  logic [XLEN-1:0]           busy_next;

  assign push_entry = '{rd: mdu_rd, data: mdu_data};
  assign head       = wb_entry_t'(head_bits);
  assign mdu_ready  = !fifo_full;
  assign fifo_push  = mdu_valid && !fifo_full;
  assign fifo_pop   = (src == SRC_FIFO);

  // Derived only from registered state so alu_valid never feeds stall_req.
  assign stall_req  = (starve == STARVE_LIM) && !fifo_empty;
  assign alu_ready  = alu_valid && !stall_req;

  wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wb_entry_t))
  ) u_mdu_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (push_entry),
    .dout  (head_bits),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    src = SRC_NONE;
    if (stall_req)        src = SRC_FIFO;
    else if (alu_valid)   src = SRC_ALU;
    else if (!fifo_empty) src = SRC_FIFO;
  end

  always_comb begin
    win_rd   = alu_rd;
    win_data = alu_data;
    if (src == SRC_FIFO) begin
      win_rd   = head.rd;
      win_data = head.data;
    end
  end

  // Clear for the committing MDU result first, then set for a new issue so set wins.
  always_comb begin
    busy_next = busy;
    if (src == SRC_FIFO) busy_next[head.rd] = 1'b0;
    if (mdu_issue && (mdu_issue_rd != '0)) busy_next[mdu_issue_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RFWr    <= 1'b0;
      WrDtAdr <= '0;
      WrDt    <= '0;
      starve  <= '0;
      busy    <= '0;
    end else begin
      RFWr <= (src != SRC_NONE) && (win_rd != '0);
      if ((src != SRC_NONE) && (win_rd != '0)) begin
        WrDtAdr <= win_rd;
        WrDt    <= win_data;
      end
      if ((src == SRC_ALU) && !fifo_empty) begin
        if (starve != STARVE_LIM) starve <= starve + STARVE_ONE;
      end else begin
        starve <= '0;
      end
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomised and directed bench for rf_wb_arbiter with a queue-based reference model
// and a decoupled write-port monitor.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned SMAX  = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        mdu_valid = 1'b0;
  logic        mdu_ready;
  logic [4:0]  mdu_rd = '0;
  logic [31:0] mdu_data = '0;
  logic        mdu_issue = 1'b0;
  logic [4:0]  mdu_issue_rd = '0;
  logic [31:0] busy;
  logic        RFWr;
  logic [4:0]  WrDtAdr;
  logic [31:0] WrDt;
  logic        stall_req;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Reference model state
  wr_t         mq[$];
  wr_t         expq[$];
  int unsigned losses = 0;
  logic [31:0] busy_m = '0;
  logic [4:0]  last_addr = '0;
  logic [31:0] last_data = '0;

  rf_wb_arbiter #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd), .mdu_data(mdu_data),
    .mdu_issue(mdu_issue), .mdu_issue_rd(mdu_issue_rd),
    .busy(busy), .RFWr(RFWr), .WrDtAdr(WrDtAdr), .WrDt(WrDt), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model decides who should win from the rules alone.
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] md,
                       input logic iv, input logic [4:0] ird);
    logic es;
    logic er;
    wr_t  e;
    @(negedge clk);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mdu_valid = mv; mdu_rd = mrd; mdu_data = md;
    mdu_issue = iv; mdu_issue_rd = ird;
    #1;
    es = (losses >= SMAX) && (mq.size() > 0);
    er = (mq.size() < DEPTH);
    check("stall_req", {31'b0, stall_req}, {31'b0, es});
    check("alu_ready", {31'b0, alu_ready}, {31'b0, av && !es});
    check("mdu_ready", {31'b0, mdu_ready}, {31'b0, er});
    check("busy", busy, busy_m);
    if (es || (!av && mq.size() > 0)) begin
      e = mq.pop_front();
      if (e.rd != 0) expq.push_back(e);
      busy_m[e.rd] = 1'b0;
      losses = 0;
    end else if (av) begin
      e.rd = ard; e.d = ad;
      if (ard != 0) expq.push_back(e);
      losses = (mq.size() > 0) ? losses + 1 : 0;
    end else begin
      losses = 0;
    end
    if (mv && er) begin
      e.rd = mrd; e.d = md;
      mq.push_back(e);
    end
    if (iv && ird != 0) busy_m[ird] = 1'b1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    alu_valid = 0; mdu_valid = 0; mdu_issue = 0;
    #1;
    check("rst_RFWr", {31'b0, RFWr}, 32'd0);
    check("rst_busy", busy, 32'd0);
    check("rst_mdu_ready", {31'b0, mdu_ready}, 32'd1);
    check("rst_stall", {31'b0, stall_req}, 32'd0);
    check("rst_WrDt", WrDt, 32'd0);
    mq.delete(); expq.delete();
    losses = 0; busy_m = '0; last_addr = '0; last_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: every write on the port must match the next expected write, in order.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (RFWr) begin
          if (expq.size() == 0) begin
            check("spurious_write_addr", {27'b0, WrDtAdr}, 32'hFFFF_FFFF);
          end else begin
            e = expq.pop_front();
            check("wr_addr", {27'b0, WrDtAdr}, {27'b0, e.rd});
            check("wr_data", WrDt, e.d);
            last_addr = e.rd;
            last_data = e.d;
          end
        end else begin
          check("hold_addr", {27'b0, WrDtAdr}, {27'b0, last_addr});
          check("hold_data", WrDt, last_data);
        end
      end
    end
  end

  initial begin
    do_reset();

    // ALU only, then an ALU write to x0
    cycle(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    cycle(1, 0, 32'h12345678, 0, 0, 0, 0, 0);
    idle(2);

    // Conflict: one MDU result against a continuous ALU stream
    cycle(1, 3, 32'h22, 1, 7, 32'h11, 1, 7);
    for (int unsigned i = 0; i < 7; i++) cycle(1, 3, 32'h22 + i, 0, 0, 0, 0, 0);
    idle(2);
    check("busy7_cleared", {31'b0, busy[7]}, 32'd0);

    // FIFO full under sustained ALU traffic
    for (int unsigned i = 0; i < 10; i++) cycle(1, 4, 32'h100 + i, 1, 5'(10 + i), 32'hA00 + i, 0, 0);
    idle(4);

    // Reset mid-burst discards pending MDU data
    cycle(1, 1, 32'h1, 1, 12, 32'hBAD0, 1, 12);
    cycle(1, 2, 32'h2, 1, 13, 32'hBAD1, 1, 13);
    do_reset();
    idle(4);

    // Scoreboard: reissue to x9 on the cycle x9 commits; issue to x0 never sets busy
    cycle(0, 0, 0, 0, 0, 0, 1, 9);
    cycle(0, 0, 0, 1, 9, 32'h99, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 9);
    idle(1);
    check("busy9_set_wins", {31'b0, busy[9]}, 32'd1);
    cycle(0, 0, 0, 1, 9, 32'h98, 1, 0);
    idle(2);
    check("busy_after_x0_issue", busy, 32'd0);

    // Randomised traffic
    for (int unsigned i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 9) < 7), 5'($urandom_range(0, 31) & (($urandom_range(0, 7) == 0) ? 0 : 31)), $urandom(),
            ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 31)), $urandom(),
            ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
    end
    for (int unsigned i = 0; i < 20 && mq.size() > 0; i++) idle(1);
    idle(3);
    check("pending_writes_left", expq.size(), 32'd0);
    check("fifo_model_left", mq.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
